// File: rtl/crc16_parallel.sv
// crc16_parallel
// Byte-parallel CRC-16 generator (MSB-first, no reflection, no final XOR).
// Absorbs one data byte per clock, echoes each byte on crc_out, then appends
// the 16-bit CRC as two bytes, high byte first.
//
// Parameters:
//   POLY     generator polynomial with implicit x^16 (default CCITT 16'h1021)
//   INIT     CRC register value at frame start
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   load     frame start; crc_in in this cycle is the first data byte
//   d_finish frame end; crc_in in this cycle is not absorbed
//   crc_in   data byte
//   crc_out  registered stream: echoed data, CRC high byte, CRC low byte
module crc16_parallel #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       d_finish,
  input  logic [7:0] crc_in,
  output logic [7:0] crc_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    OUT_HI = 2'd2,
    OUT_LO = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  out_q, out_d;

  // One byte folded into the CRC: the byte enters the top of the register,
  // then eight unrolled shift/conditional-XOR steps.
  function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (r[15]) begin
        r = {r[14:0], 1'b0} ^ POLY;
      end else begin
        r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  // Next-state, next-CRC and next output byte.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    out_d   = 8'h00;
    case (state_q)
      IDLE: begin
        if (load) begin
          crc_d   = crc_update(INIT, crc_in);
          out_d   = crc_in;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // load wins over d_finish: a fresh frame starts with this byte.
        if (load) begin
          crc_d   = crc_update(INIT, crc_in);
          out_d   = crc_in;
          state_d = CALC;
        end else if (d_finish) begin
          out_d   = crc_q[15:8];
          state_d = OUT_HI;
        end else begin
          crc_d   = crc_update(crc_q, crc_in);
          out_d   = crc_in;
          state_d = CALC;
        end
      end
      // Trailer bytes always complete; load/d_finish are not looked at here.
      OUT_HI: begin
        out_d   = crc_q[7:0];
        state_d = OUT_LO;
      end
      OUT_LO: begin
        out_d   = 8'h00;
        state_d = IDLE;
      end
      default: begin
        out_d   = 8'h00;
        state_d = IDLE;
      end
    endcase
  end

  // State, CRC and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
    end
  end

  assign crc_out = out_q;

endmodule

// File: tb/tb_crc16_parallel.sv
// Self-checking bench for crc16_parallel. The driver pushes the byte expected
// on crc_out after each clock edge into a queue; a monitor pops and compares
// on every falling edge.
module tb_crc16_parallel;

  logic       clk;
  logic       rst;
  logic       load;
  logic       d_finish;
  logic [7:0] crc_in;
  logic [7:0] crc_out;

  logic [7:0] exp_q[$];
  int         tests;
  int         failed;
  int         step;

  crc16_parallel #(.POLY(16'h1021), .INIT(16'h0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .d_finish (d_finish),
    .crc_in   (crc_in),
    .crc_out  (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: one input bit at a time, feedback = msb ^ data bit.
  function automatic logic [15:0] sw_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Drive one cycle of inputs and record what crc_out must show after the edge.
  task automatic cyc(input logic r, input logic l, input logic f,
                     input logic [7:0] d, input logic [7:0] e);
    rst      = r;
    load     = l;
    d_finish = f;
    crc_in   = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the output stream against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step++;
      tests++;
      if (crc_out !== e) begin
        failed++;
        $display("FAIL crc_out step %0d: got %02h expected %02h", step, crc_out, e);
      end
    end
  end

  initial begin
    logic [15:0] m;
    logic [7:0]  d;
    tests = 0; failed = 0; step = 0;

    // Reset for two cycles at start.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Single byte frame: AA -> AA, 14, A0, 00.
    cyc(1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h14);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'hA0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Check string "123456789" -> trailer 31 C3.
    cyc(1'b0, 1'b1, 1'b0, 8'h31, 8'h31);
    for (int i = 2; i <= 9; i++) begin
      d = 8'h30 + 8'(i);
      cyc(1'b0, 1'b0, 1'b0, d, d);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'hFF, 8'h31);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'hC3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset for two cycles mid-CALC, then a frame must compute from INIT.
    cyc(1'b0, 1'b1, 1'b0, 8'h12, 8'h12);
    cyc(1'b0, 1'b0, 1'b0, 8'h34, 8'h34);
    cyc(1'b1, 1'b0, 1'b0, 8'h56, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h78, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h9A, 8'h00);   // d_finish in IDLE: no effect
    cyc(1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h14);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'hA0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Alternating stream AA,55,... (11 bytes).
    cyc(1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA);
    m = sw_step(16'h0000, 8'hAA);
    for (int i = 1; i <= 10; i++) begin
      d = (i % 2 == 1) ? 8'h55 : 8'hAA;
      cyc(1'b0, 1'b0, 1'b0, d, d);
      m = sw_step(m, d);
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, m[15:8]);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, m[7:0]);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Priority: load with d_finish in CALC restarts with the current byte.
    cyc(1'b0, 1'b1, 1'b0, 8'h31, 8'h31);
    cyc(1'b0, 1'b0, 1'b0, 8'h32, 8'h32);
    cyc(1'b0, 1'b1, 1'b1, 8'h41, 8'h41);
    cyc(1'b0, 1'b0, 1'b0, 8'h42, 8'h42);
    m = sw_step(sw_step(16'h0000, 8'h41), 8'h42);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, m[15:8]);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, m[7:0]);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // d_finish alone in IDLE: output stays 00.
    cyc(1'b0, 1'b0, 1'b1, 8'h5A, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Trailer lock: load during OUT_HI and OUT_LO is ignored; load accepted
    // three cycles after d_finish.
    cyc(1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h14);
    cyc(1'b0, 1'b1, 1'b0, 8'h77, 8'hA0);
    cyc(1'b0, 1'b1, 1'b1, 8'h66, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h55, 8'h55);
    m = sw_step(16'h0000, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, m[15:8]);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, m[7:0]);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during the trailer aborts it.
    cyc(1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h14);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Let the monitor drain the last entry, then confirm nothing is left.
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
